// File: rtl/data_sram_responder_if.sv
// Byte-select SRAM-like bus between the CPU MEM stage (master) and the data responder (slave).
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-port memory responder: one outstanding request, fixed LATENCY, byte-lane writes into a word RAM,
// raw word reads, and legality checking that turns bad requests into err responses.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  bus
);

    localparam int       DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);
    // With LATENCY = 1 the commit edge is the accept edge, so the bus fields are used directly.
    localparam bit       DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           wdata_q;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  latch_en;
    logic                  commit;
    logic                  illegal;
    logic                  c_wr;
    logic [1:0]            c_size;
    logic [ADDR_WIDTH+1:0] c_addr;
    logic [3:0]            c_wstrb;
    logic [31:0]           c_wdata;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic                  unused_addr_hi;

    function automatic logic req_illegal(input logic w, input logic [1:0] sz,
                                         input logic [1:0] off, input logic [3:0] st);
        logic bad;
        bad = 1'b0;
        if (sz == 2'b11) begin
            bad = 1'b1;
        end else if (!w) begin
            bad = (sz == 2'b01) && off[0];
        end else begin
            case (sz)
                2'b00:   bad = (st != (4'b0001 << off));
                2'b01:   bad = off[0] || (st != (off[1] ? 4'b1100 : 4'b0011));
                default: bad = !(st inside {4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                            4'b1110, 4'b1100, 4'b1000});
            endcase
        end
        return bad;
    endfunction

    assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

    assign bus.addr_ok = (state_q != WAIT);
    assign bus.data_ok = (state_q == RESP);
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;

    assign accept = bus.req && bus.addr_ok;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    latch_en = 1'b1;
                    cnt_d    = LAT_M1;
                    state_d  = DIRECT ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign c_wr    = DIRECT ? bus.wr                     : wr_q;
    assign c_size  = DIRECT ? bus.size                   : size_q;
    assign c_addr  = DIRECT ? bus.addr[ADDR_WIDTH+1:0]   : addr_q;
    assign c_wstrb = DIRECT ? bus.wstrb                  : wstrb_q;
    assign c_wdata = DIRECT ? bus.wdata                  : wdata_q;
    assign c_idx   = c_addr[ADDR_WIDTH+1:2];

    // A held reset must never let a commit reach the RAM, which has no reset of its own.
    assign commit  = resetn && (state_d == RESP);
    assign illegal = req_illegal(c_wr, c_size, c_addr[1:0], c_wstrb);

    always_comb begin
        rdata_d = rdata_q;
        if (commit && !c_wr && !illegal) rdata_d = mem[c_idx];
        err_d = commit && illegal;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            wr_q    <= bus.wr;
            size_q  <= bus.size;
            addr_q  <= bus.addr[ADDR_WIDTH+1:0];
            wstrb_q <= bus.wstrb;
            wdata_q <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_wr && !illegal) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wstrb[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: LATENCY 2 (main), LATENCY 1 (throughput) and LATENCY 3 (reset mid-WAIT) instances.
module tb_data_sram_responder;

    logic clk;
    logic rstn1, rstn2, rstn3;
    int   n_chk;
    int   n_fail;

    data_sram_responder_if if1 ();
    data_sram_responder_if if2 ();
    data_sram_responder_if if3 ();

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (.clk(clk), .resetn(rstn1), .bus(if1));
    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut2 (.clk(clk), .resetn(rstn2), .bus(if2));
    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut3 (.clk(clk), .resetn(rstn3), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for dut2 / dut3, steered by sel (0 = dut2, 1 = dut3).
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    int          sel;

    assign if2.req = s_req && (sel == 0);
    assign if3.req = s_req && (sel == 1);
    assign if2.wr = s_wr;       assign if3.wr = s_wr;
    assign if2.size = s_size;   assign if3.size = s_size;
    assign if2.addr = s_addr;   assign if3.addr = s_addr;
    assign if2.wstrb = s_wstrb; assign if3.wstrb = s_wstrb;
    assign if2.wdata = s_wdata; assign if3.wdata = s_wdata;

    logic        o_aok, o_dok, o_err;
    logic [31:0] o_rdata;
    assign o_aok   = (sel == 1) ? if3.addr_ok : if2.addr_ok;
    assign o_dok   = (sel == 1) ? if3.data_ok : if2.data_ok;
    assign o_err   = (sel == 1) ? if3.err     : if2.err;
    assign o_rdata = (sel == 1) ? if3.rdata   : if2.rdata;

    // Issues one request, then waits (bounded) for its data_ok; lat = 0 means no response seen.
    task automatic xfer(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd,
                        output logic aok, output logic aok_wait, output logic [31:0] rd,
                        output logic er, output int lat);
        rd = 32'hDEAD_BEEF; er = 1'bx; lat = 0; aok_wait = 1'bx;
        @(posedge clk); #1;
        s_req = 1'b1; s_wr = w; s_size = sz; s_addr = a; s_wstrb = st; s_wdata = wd;
        @(negedge clk); aok = o_aok;
        @(posedge clk); #1;
        s_req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) aok_wait = o_aok;
            if (o_dok) begin
                lat = n; rd = o_rdata; er = o_err;
                break;
            end
        end
    endtask

    logic        aok, aokw, er;
    logic [31:0] rd;
    int          lat;

    task automatic test_reset;
        rstn1 = 1'b0; rstn2 = 1'b0; rstn3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (if2.addr_ok !== 1'b1) begin n_fail++; $display("FAIL rst_addr_ok: got %b want 1", if2.addr_ok); end
        n_chk++; if (if2.data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_ok: got %b want 0", if2.data_ok); end
        n_chk++; if (if2.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", if2.err); end
        n_chk++; if (if2.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 00000000", if2.rdata); end
        rstn1 = 1'b1; rstn2 = 1'b1; rstn3 = 1'b1;
    endtask

    task automatic test_word_write_read;
        sel = 0;
        xfer(1'b1, 2'b10, 32'h100, 4'b1111, 32'h12345678, aok, aokw, rd, er, lat);
        n_chk++; if (aok !== 1'b1) begin n_fail++; $display("FAIL first_accept: addr_ok got %b want 1", aok); end
        n_chk++; if (aokw !== 1'b0) begin n_fail++; $display("FAIL wait_addr_ok: got %b want 0", aokw); end
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", er); end
        xfer(1'b0, 2'b10, 32'h100, 4'b0000, 32'h0, aok, aokw, rd, er, lat);
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d want 2", lat); end
        n_chk++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL word_read: got %h want 12345678", rd); end
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
        @(negedge clk);
        n_chk++; if (o_dok !== 1'b0) begin n_fail++; $display("FAIL dok_pulse: got %b want 0", o_dok); end
    endtask

    task automatic test_byte_write;
        sel = 0;
        xfer(1'b1, 2'b00, 32'h101, 4'b0010, 32'h0000AB00, aok, aokw, rd, er, lat);
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL byte_wr_err: got %b want 0", er); end
        n_chk++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rdata_hold_wr: got %h want 12345678", rd); end
        xfer(1'b0, 2'b10, 32'h100, 4'b0000, 32'h0, aok, aokw, rd, er, lat);
        n_chk++; if (rd !== 32'h1234AB78) begin n_fail++; $display("FAIL byte_merge: got %h want 1234ab78", rd); end
    endtask

    task automatic test_partial_store;
        sel = 0;
        xfer(1'b1, 2'b10, 32'h102, 4'b1100, 32'hCDEF0000, aok, aokw, rd, er, lat);
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL swr_err: got %b want 0", er); end
        xfer(1'b0, 2'b10, 32'h100, 4'b0000, 32'h0, aok, aokw, rd, er, lat);
        n_chk++; if (rd !== 32'hCDEFAB78) begin n_fail++; $display("FAIL swr_merge: got %h want cdefab78", rd); end
    endtask

    typedef struct { logic w; logic [1:0] sz; logic [31:0] a; logic [3:0] st; logic [31:0] wd; } bad_t;

    task automatic test_illegal;
        bad_t bad [5];
        sel = 0;
        bad[0] = '{1'b1, 2'b01, 32'h101, 4'b0011, 32'h11111111};
        bad[1] = '{1'b0, 2'b11, 32'h100, 4'b0000, 32'h0};
        bad[2] = '{1'b1, 2'b00, 32'h103, 4'b0001, 32'h22222222};
        bad[3] = '{1'b0, 2'b01, 32'h101, 4'b0000, 32'h0};
        bad[4] = '{1'b1, 2'b10, 32'h100, 4'b0110, 32'h33333333};
        for (int i = 0; i < 5; i++) begin
            xfer(bad[i].w, bad[i].sz, bad[i].a, bad[i].st, bad[i].wd, aok, aokw, rd, er, lat);
            n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL illegal_err[%0d]: got %b want 1", i, er); end
            n_chk++; if (rd !== 32'hCDEFAB78) begin n_fail++; $display("FAIL illegal_rdata[%0d]: got %h want cdefab78", i, rd); end
        end
        @(negedge clk);
        n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b want 0", o_err); end
        xfer(1'b0, 2'b10, 32'h103, 4'b0000, 32'h0, aok, aokw, rd, er, lat);
        n_chk++; if (rd !== 32'hCDEFAB78 || er !== 1'b0) begin n_fail++; $display("FAIL ram_unchanged: got %h/%b want cdefab78/0", rd, er); end
        xfer(1'b0, 2'b10, 32'h4100, 4'b0000, 32'h0, aok, aokw, rd, er, lat);
        n_chk++; if (rd !== 32'hCDEFAB78) begin n_fail++; $display("FAIL alias_read: got %h want cdefab78", rd); end
    endtask

    task automatic test_back_to_back;
        logic        vw [6];
        logic [31:0] va [6];
        logic [31:0] vd [6];
        vw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        va = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
        vd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h0};
        @(posedge clk); #1;
        if1.req = 1'b1; if1.wr = vw[0]; if1.addr = va[0]; if1.wdata = vd[0];
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k < 5) begin
                if1.wr = vw[k+1]; if1.addr = va[k+1]; if1.wdata = vd[k+1];
            end else begin
                if1.req = 1'b0;
            end
            @(negedge clk);
            n_chk++; if (if1.data_ok !== 1'b1 || if1.addr_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_ok[%0d]: got dok=%b aok=%b want 1/1", k, if1.data_ok, if1.addr_ok); end
            if (k >= 3) begin
                n_chk++; if (if1.rdata !== vd[k-3]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, if1.rdata, vd[k-3]); end
            end
        end
        @(negedge clk);
        n_chk++; if (if1.data_ok !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", if1.data_ok); end
    endtask

    task automatic test_reset_mid_wait;
        logic seen;
        sel = 1;
        xfer(1'b1, 2'b10, 32'h200, 4'b1111, 32'hA5A5A5A5, aok, aokw, rd, er, lat);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL lat3: got %0d want 3", lat); end
        @(posedge clk); #1;
        s_req = 1'b1; s_wr = 1'b1; s_size = 2'b10; s_addr = 32'h200; s_wstrb = 4'b1111; s_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        s_req = 1'b0;
        @(negedge clk); rstn3 = 1'b0;
        @(negedge clk); rstn3 = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (o_dok) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dropped_resp: data_ok seen %b want 0", seen); end
        n_chk++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL rst3_rdata: got %h want 00000000", o_rdata); end
        xfer(1'b0, 2'b10, 32'h200, 4'b0000, 32'h0, aok, aokw, rd, er, lat);
        n_chk++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL no_commit: got %h want a5a5a5a5", rd); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; sel = 0;
        s_req = 1'b0; s_wr = 1'b0; s_size = 2'b10; s_addr = 32'h0; s_wstrb = 4'b0; s_wdata = 32'h0;
        if1.req = 1'b0; if1.wr = 1'b0; if1.size = 2'b10; if1.addr = 32'h0; if1.wstrb = 4'b1111; if1.wdata = 32'h0;
        test_reset();
        test_word_write_read();
        test_byte_write();
        test_partial_store();
        test_illegal();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data port: the slave end of the byte-select interface the MEM stage drives (sel/size/aligned write data).
- Accepts one request at a time over an SRAM-like req/addr_ok/data_ok handshake.
- Applies byte-lane write strobes to an internal word RAM and returns the raw 32-bit word for reads; lane extraction and sign extension remain in the CPU.
- Checks strobe/size/address legality and flags illegal requests instead of committing them.

Parameters:
ADDR_WIDTH, 12, word-index bits; RAM depth = 2**ADDR_WIDTH words.
LATENCY, 2, cycles from accept edge to data_ok cycle; legal range 1..7.

Ports:
clk  input  1  clock, rising edge.
resetn  input  1  asynchronous active-low reset.
req  input  1  request valid.
wr  input  1  1 = write, 0 = read.
size  input  2  00 byte, 01 half, 10 word, 11 illegal.
addr  input  32  byte address.
wstrb  input  4  byte-lane enables, writes only.
wdata  input  32  lane-aligned write data.
addr_ok  output  1  request accepted this cycle when req is also high.
data_ok  output  1  one-cycle response pulse.
rdata  output  32  read word, valid while data_ok = 1.
err  output  1  illegal request flag, valid with data_ok.

Behaviour:
- Reset: asynchronous, active-low on resetn; synchronous release on clk.
- Reset values:
  - state = IDLE, counter = 0
  - addr_ok = 1, data_ok = 0, err = 0, rdata = 32'h0
  - RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
  - addr_ok = 1 in IDLE and RESP; 0 in WAIT.
  - data_ok = 1 only in RESP.
- Accept: req && addr_ok at a rising edge.
  - Latches wr, size, addr, wstrb, wdata.
  - Loads cnt = LATENCY-1.
  - Next state is RESP if LATENCY = 1, else WAIT.
- WAIT: cnt decrements each cycle. When cnt = 1, the next state is RESP. data_ok is high exactly LATENCY cycles after the accept edge.
- Commit: on the edge entering RESP.
  - Legal write: RAM[addr[ADDR_WIDTH+1:2]] byte lane i is updated from wdata[8i+7:8i] for every wstrb[i] = 1.
  - Legal read: rdata is loaded with the full RAM word at that index.
- RESP: lasts one cycle.
  - New accept in this cycle: reload the counter and go to WAIT or RESP as above, giving back-to-back throughput of one request per LATENCY cycles.
  - No accept: go to IDLE.
- rdata holds its last read value across write responses and idle cycles.
- err logic:
  - err is computed from the latched fields and registered on the commit edge.
  - err = 1 suppresses any RAM write and leaves rdata unchanged.
  - err is 0 whenever data_ok = 0.
- Illegal conditions:
  - size = 11.
  - Read with size 01 and addr[0] = 1.
  - Write with size 00 and wstrb != one-hot(addr[1:0]), i.e. 0001/0010/0100/1000 for offsets 0..3.
  - Write with size 01 and addr[0] = 1, or wstrb != (addr[1] ? 1100 : 0011).
  - Write with size 10 and wstrb not in {0001, 0011, 0111, 1111, 1110, 1100, 1000}. These are the partial-word left/right store patterns; word addr alignment is not checked.
  - Word reads at any offset are legal (partial-word loads merge in the CPU).
- Address bits above ADDR_WIDTH+1 are ignored, so the RAM aliases.
- While addr_ok = 0, req and the request fields may change freely with no effect.
- Reset asserted in WAIT: the outstanding request is dropped, no RAM write occurs, and no data_ok is issued after release.
- Reset asserted in RESP after the commit edge: the write is already committed and remains in the RAM.
- RAM read and write with the same index at the same edge cannot occur: only one commit per edge.

Test Plan:
- Reset values: hold resetn = 0 -> addr_ok = 1, data_ok = 0, err = 0, rdata = 0; release -> state IDLE, first req accepted immediately.
- Word write then read: write addr = 0x100, wstrb = 1111, wdata = 0x12345678 accepted at edge T -> data_ok in cycle T+2 (LATENCY = 2). Then read 0x100 -> rdata = 0x12345678, err = 0.
- Byte write: byte write addr = 0x101, size = 00, wstrb = 0010, wdata = 0x0000AB00 over word 0x12345678 -> read 0x100 returns 0x1234AB78.
- Partial-word right store: write addr = 0x102, wstrb = 1100, wdata = 0xCDEF0000 -> read returns 0xCDEFAB78.
- Illegal half write: half write addr = 0x101, wstrb = 0011 -> data_ok with err = 1, RAM unchanged, rdata unchanged.
- Throughput and reset: req held high with LATENCY = 1 -> a new accept on every RESP cycle, data_ok high every cycle, reads return the prior writes in order.
- Reset mid-WAIT: LATENCY = 3, write 0xFFFFFFFF to 0x200, pulse resetn low in WAIT -> no data_ok afterwards; read 0x200 returns its old value.
